pspi_slave_param: RTL and testbench

Parametrised PSPI slave: full-duplex, MSB-first serial shifter with configurable word width, a parity bit on both directions and a transmit holding register. It runs entirely on the system clock `clkin`, oversamples the master's `sclk`/`ss_n`/`mosi`, and delivers received words and flags as single-cycle strobes to the local parallel side. It replaces the fixed 8-bit slave in new designs.

---
 rtl/pspi_slave_param.sv | 215 +++++++++++++++++++++
 tb/tb_pspi_slave_param.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pspi_slave_param.sv
// pspi_slave_param: parametrised MSB-first mode-0 PSPI slave on clkin.
// Define PSPI_PARITY_EN to add a parity bit in both directions.
module pspi_slave_param #(
  parameter int DATA_W      = 8,
  parameter int PARITY_ODD  = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clkin,
  input  logic              rstn,
  input  logic              en,
  input  logic              sclk,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_perr,
  output logic              frame_err,
  output logic              busy
);

`ifdef PSPI_PARITY_EN
  localparam int PE = 1;
`else
  localparam int PE = 0;
`endif
  localparam int FL = DATA_W + PE;
  localparam int CW = $clog2(FL + 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SHIFT    = 2'd1;
  localparam logic [1:0] COMPLETE = 2'd2;

  function automatic logic par_of(
    input logic [DATA_W-1:0] w
  );
    return (^w) ^ (PARITY_ODD != 0);
  endfunction

  logic [SYNC_STAGES-1:0] sclk_s;
  logic [SYNC_STAGES-1:0] ss_s;
  logic [SYNC_STAGES-1:0] mosi_s;
  logic                   sclk_d;
  logic                   ss_d;

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      sclk_s <= '0;
      ss_s   <= '1;
      mosi_s <= '0;
      sclk_d <= 1'b0;
      ss_d   <= 1'b1;
    end else begin
      sclk_s <= {sclk_s[SYNC_STAGES-2:0], sclk};
      ss_s   <= {ss_s[SYNC_STAGES-2:0], ss_n};
      mosi_s <= {mosi_s[SYNC_STAGES-2:0], mosi};
      sclk_d <= sclk_s[SYNC_STAGES-1];
      ss_d   <= ss_s[SYNC_STAGES-1];
    end
  end

  logic sclk_q;
  logic ss_q;
  logic mosi_q;
  logic sclk_rise;
  logic sclk_fall;
  logic ss_fall;

  assign sclk_q    = sclk_s[SYNC_STAGES-1];
  assign ss_q      = ss_s[SYNC_STAGES-1];
  assign mosi_q    = mosi_s[SYNC_STAGES-1];
  assign sclk_rise = sclk_q & ~sclk_d;
  assign sclk_fall = ~sclk_q & sclk_d;
  assign ss_fall   = ~ss_q & ss_d;

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] tx_sh;
  logic [FL-1:0]     rx_sh;
  logic [DATA_W-1:0] hold_data;
  logic              hold_full;
  logic              take;
  logic              start;
  logic              reload;
  logic              load_sh;
  logic [DATA_W-1:0] next_word;

  assign tx_ready = ~hold_full;
  assign busy     = (state != IDLE);
  assign take     = tx_valid & ~hold_full;
  assign start    = en & (state == IDLE) & ss_fall;
  assign reload   = en & (state == COMPLETE) & ~ss_q;
  assign load_sh  = start | reload;

  // A word offered in the same cycle as a load wins over an empty holding.
  always_comb begin
    next_word = '0;
    if (take)
      next_word = tx_data;
    else if (hold_full)
      next_word = hold_data;
  end

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (load_sh) begin
      hold_full <= 1'b0;
    end else if (take) begin
      hold_full <= 1'b1;
      hold_data <= tx_data;
    end
  end

`ifdef PSPI_PARITY_EN
  logic tx_par;
  logic perr_q;

  assign rx_perr = perr_q;

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      tx_par <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      perr_q <= 1'b0;
      if (load_sh)
        tx_par <= par_of(next_word);
      if (en && state == COMPLETE)
        perr_q <= (^rx_sh) ^ (PARITY_ODD != 0);
    end
  end
`else
  assign rx_perr = 1'b0;
`endif

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      miso      <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (!en) begin
        state <= IDLE;
        cnt   <= '0;
        miso  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            miso <= 1'b0;
            cnt  <= '0;
            if (ss_fall) begin
              state <= SHIFT;
              miso  <= next_word[DATA_W-1];
              tx_sh <= {next_word[DATA_W-2:0], 1'b0};
            end
          end
          SHIFT: begin
            if (ss_q) begin
              state     <= IDLE;
              miso      <= 1'b0;
              cnt       <= '0;
              frame_err <= (cnt != '0);
            end else if (sclk_rise) begin
              rx_sh <= {rx_sh[FL-2:0], mosi_q};
              cnt   <= cnt + 1'b1;
              if (cnt == CW'(FL - 1))
                state <= COMPLETE;
            end else if (sclk_fall) begin
              if (cnt < CW'(DATA_W)) begin
                miso  <= tx_sh[DATA_W-1];
                tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
              end
`ifdef PSPI_PARITY_EN
              else begin
                miso <= tx_par;
              end
`endif
            end
          end
          COMPLETE: begin
            rx_data  <= rx_sh[FL-1 -: DATA_W];
            rx_valid <= 1'b1;
            cnt      <= '0;
            // Back-to-back: first bit goes out on the next sclk fall.
            if (!ss_q) begin
              state <= SHIFT;
              tx_sh <= next_word;
            end else begin
              state <= IDLE;
              miso  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            miso  <= 1'b0;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pspi_slave_param.sv
// tb_pspi_slave_param: directed bench with rx scoreboard.
// Word width follows PSPI_PARITY_EN (8 with parity, 12 without).
module tb_pspi_slave_param;

`ifdef PSPI_PARITY_EN
  localparam int PE = 1;
  localparam int DW = 8;
`else
  localparam int PE = 0;
  localparam int DW = 12;
`endif
  localparam int FL = DW + PE;
  localparam int HP = 8;
  localparam logic PODD = 1'b1;

  logic          clkin;
  logic          rstn;
  logic          en;
  logic          sclk;
  logic          ss_n;
  logic          mosi;
  logic          miso;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_perr;
  logic          frame_err;
  logic          busy;

  pspi_slave_param #(.DATA_W(DW)) dut (
    .clkin(clkin), .rstn(rstn), .en(en),
    .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_perr(rx_perr), .frame_err(frame_err),
    .busy(busy)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  int n_chk;
  int n_fail;
  int fe_cnt;
  int rx_cnt;
  logic [DW:0] sb[$];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic par(input logic [DW-1:0] w);
    return (^w) ^ PODD;
  endfunction

  function automatic logic [FL-1:0] mkf(
    input logic [DW-1:0] w, input logic p);
    logic [DW:0] t;
    t = {w, p};
    if (PE != 0) return FL'(t);
    return FL'(t >> 1);
  endfunction

  always @(negedge clkin) begin
    if (rstn) begin
      if (rx_valid) begin
        rx_cnt++;
        if (sb.size() == 0) begin
          check("rx_unexpected", 32'(rx_valid), 32'd0);
        end else begin
          logic [DW:0] e;
          e = sb.pop_front();
          check("rx_data", 32'(rx_data), 32'(e[DW-1:0]));
          check("rx_perr", 32'(rx_perr), 32'(e[DW]));
        end
      end
      if (frame_err) fe_cnt++;
    end
  end

  task automatic chk_reset(input string tag);
    check({tag, "_miso"}, 32'(miso), 32'd0);
    check({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
    check({tag, "_rx_data"}, 32'(rx_data), 32'd0);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_rx_perr"}, 32'(rx_perr), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic load(input logic [DW-1:0] w);
    @(negedge clkin);
    tx_data  = w;
    tx_valid = 1'b1;
    @(negedge clkin);
    tx_valid = 1'b0;
  endtask

  task automatic xfer(input logic [FL-1:0] f,
                      input int s, input int n,
                      inout logic [FL-1:0] cap);
    for (int i = s; i < s + n; i++) begin
      mosi = f[FL-1-i];
      repeat (HP) @(posedge clkin);
      #1;
      cap[FL-1-i] = miso;
      sclk = 1'b1;
      repeat (HP) @(posedge clkin);
      #1;
      sclk = 1'b0;
    end
  endtask

  task automatic wait_sb(input string tag);
    for (int i = 0; i < 200 && sb.size() != 0; i++)
      @(posedge clkin);
    check(tag, sb.size(), 32'd0);
  endtask

  logic [FL-1:0] cap;
  logic [DW-1:0] w3c;
  logic [DW-1:0] wa;
  int            rx0;
  logic          bad_p;

  initial begin
    n_chk = 0; n_fail = 0; fe_cnt = 0; rx_cnt = 0;
    rstn = 1'b0; en = 1'b1; sclk = 1'b0; ss_n = 1'b1;
    mosi = 1'b0; tx_data = '0; tx_valid = 1'b0;
    w3c = DW'(32'h03C);
    wa  = DW'(32'hABC);
    repeat (3) @(posedge clkin);
    #1;
    chk_reset("rst");
    rstn = 1'b1;
    repeat (5) @(posedge clkin);

    load(DW'(32'hA5));
    check("hold_full", 32'(tx_ready), 32'd0);
    ss_n = 1'b0;
    repeat (6) @(posedge clkin);
    #1;
    check("busy_start", 32'(busy), 32'd1);
    sb.push_back({1'b0, w3c});
    cap = '0;
    xfer(mkf(w3c, par(w3c)), 0, FL, cap);
    check("f1_miso", 32'(cap),
          32'(mkf(DW'(32'hA5), par(DW'(32'hA5)))));
    repeat (HP) @(posedge clkin);
    ss_n = 1'b1;
    wait_sb("f1_drain");
    repeat (HP) @(posedge clkin);
    #1;
    check("f1_tx_ready", 32'(tx_ready), 32'd1);
    check("f1_busy", 32'(busy), 32'd0);
    check("f1_no_ferr", fe_cnt, 32'd0);

    bad_p = (PE != 0);
    ss_n = 1'b0;
    sb.push_back({bad_p, wa});
    cap = '0;
    xfer(mkf(wa, ~par(wa)), 0, FL, cap);
    check("f2_miso_empty", 32'(cap), 32'(mkf('0, par('0))));
    repeat (HP) @(posedge clkin);
    ss_n = 1'b1;
    wait_sb("f2_drain");

    ss_n = 1'b0;
    cap = '0;
    xfer(mkf(DW'(32'h55), 1'b0), 0, 4, cap);
    repeat (HP) @(posedge clkin);
    ss_n = 1'b1;
    for (int i = 0; i < 50 && fe_cnt == 0; i++)
      @(posedge clkin);
    repeat (20) @(posedge clkin);
    #1;
    check("abort_ferr_once", fe_cnt, 32'd1);
    check("abort_rx_kept", 32'(rx_data), 32'(wa));
    check("abort_busy", 32'(busy), 32'd0);

    rx0 = rx_cnt;
    load(DW'(32'h96));
    ss_n = 1'b0;
    sb.push_back({1'b0, DW'(32'h01)});
    cap = '0;
    xfer(mkf(DW'(32'h01), par(DW'(32'h01))), 0, 3, cap);
    load(DW'(32'h5A));
    check("b2b_hold", 32'(tx_ready), 32'd0);
    xfer(mkf(DW'(32'h01), par(DW'(32'h01))), 3, FL - 3, cap);
    check("b2b_miso0", 32'(cap),
          32'(mkf(DW'(32'h96), par(DW'(32'h96)))));
    sb.push_back({1'b0, DW'(32'hFF)});
    cap = '0;
    xfer(mkf(DW'(32'hFF), par(DW'(32'hFF))), 0, FL, cap);
    check("b2b_miso1", 32'(cap),
          32'(mkf(DW'(32'h5A), par(DW'(32'h5A)))));
    sb.push_back({1'b0, wa});
    cap = '0;
    xfer(mkf(wa, par(wa)), 0, FL, cap);
    check("b2b_miso2", 32'(cap), 32'(mkf('0, par('0))));
    repeat (HP) @(posedge clkin);
    ss_n = 1'b1;
    wait_sb("b2b_drain");
    check("b2b_pulses", rx_cnt - rx0, 32'd3);
    check("b2b_no_ferr", fe_cnt, 32'd1);

    ss_n = 1'b0;
    cap = '0;
    xfer(mkf(DW'(32'h33), 1'b0), 0, 3, cap);
    rstn = 1'b0;
    #1;
    chk_reset("mid_rst");
    ss_n = 1'b1;
    repeat (4) @(posedge clkin);
    rstn = 1'b1;
    repeat (5) @(posedge clkin);
    ss_n = 1'b0;
    sb.push_back({1'b0, DW'(32'h81)});
    cap = '0;
    xfer(mkf(DW'(32'h81), par(DW'(32'h81))), 0, FL, cap);
    check("post_rst_miso", 32'(cap), 32'(mkf('0, par('0))));
    repeat (HP) @(posedge clkin);
    ss_n = 1'b1;
    wait_sb("post_rst_drain");
    check("post_rst_rx", 32'(rx_data), 32'h81);

    rx0 = rx_cnt;
    ss_n = 1'b0;
    cap = '0;
    xfer(mkf(DW'(32'h0F), 1'b0), 0, 3, cap);
    en = 1'b0;
    repeat (2) @(posedge clkin);
    #1;
    check("en_off_busy", 32'(busy), 32'd0);
    check("en_off_miso", 32'(miso), 32'd0);
    ss_n = 1'b1;
    repeat (10) @(posedge clkin);
    en = 1'b1;
    repeat (10) @(posedge clkin);
    #1;
    check("en_off_no_ferr", fe_cnt, 32'd1);
    check("en_off_no_rx", rx_cnt - rx0, 32'd0);

    repeat (10) @(posedge clkin);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
